duty_cycle_gen: RTL and testbench

//  Programmable PWM stimulus source. It is the transmit-side counterpart of

---
 rtl/duty_cycle_pkg.sv | 12 +
 rtl/phase_down_cnt.sv | 38 +++
 rtl/duty_cycle_gen.sv | 155 +++++++++++++++
 tb/tb_duty_cycle_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/duty_cycle_pkg.sv
// rtl/duty_cycle_pkg.sv - shared count width and FSM encoding for the duty-cycle gen/meter family
package duty_cycle_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/phase_down_cnt.sv
// rtl/phase_down_cnt.sv - phase length down-counter with load, decrement and zero flag
module phase_down_cnt
  import duty_cycle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/duty_cycle_gen.sv
// rtl/duty_cycle_gen.sv - programmable PWM source: high/low phase lengths applied only at period boundaries
module duty_cycle_gen
  import duty_cycle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_high_cnt,
  input  logic [CNT_W-1:0] cfg_low_cnt,
  output logic             sig_out,
  output logic             period_done,
  output logic             cfg_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [CNT_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_vld_q, pend_vld_d;
  logic             sig_q, sig_d, pd_q, pd_d, err_q, err_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;
  logic [CNT_W-1:0] nxt_hi, nxt_lo;
  logic             start, period_end;

  phase_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (sys_clk),
    .rst_n_i    (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered, so period_done is predicted one edge ahead from the next count.
  always_comb begin
    state_d      = state_q;
    act_hi_d     = act_hi_q;
    act_lo_d     = act_lo_q;
    pend_vld_d   = pend_vld_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    sig_d        = 1'b0;
    pd_d         = 1'b0;
    err_d        = 1'b0;
    start        = 1'b0;
    period_end   = 1'b0;
    nxt_hi       = pend_vld_q ? pend_hi_q : act_hi_q;
    nxt_lo       = pend_vld_q ? pend_lo_q : act_lo_q;

    if (cfg_valid && !pend_vld_q) begin
      if ((cfg_high_cnt == '0) && (cfg_low_cnt == '0)) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_hi_d  = cfg_high_cnt;
        pend_lo_d  = cfg_low_cnt;
      end
    end

    case (state_q)
      ST_IDLE: start = en && (pend_vld_q || (act_hi_q != '0) || (act_lo_q != '0));
      ST_HIGH: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          sig_d   = 1'b1;
          pd_d    = (act_lo_q == '0) && (cnt_val == ONE);
        end else if (act_lo_q != '0) begin
          state_d      = ST_LOW;
          cnt_load     = 1'b1;
          cnt_load_val = act_lo_q - ONE;
          pd_d         = (act_lo_q == ONE);
        end else begin
          period_end = 1'b1;
        end
      end
      ST_LOW: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          pd_d    = (cnt_val == ONE);
        end else begin
          period_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (period_end) begin
      if (en) begin
        start = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (start) begin
      act_hi_d   = nxt_hi;
      act_lo_d   = nxt_lo;
      pend_vld_d = 1'b0;
      cnt_load   = 1'b1;
      if (nxt_hi != '0) begin
        state_d      = ST_HIGH;
        cnt_load_val = nxt_hi - ONE;
        sig_d        = 1'b1;
        pd_d         = (nxt_lo == '0) && (nxt_hi == ONE);
      end else begin
        state_d      = ST_LOW;
        cnt_load_val = nxt_lo - ONE;
        pd_d         = (nxt_lo == ONE);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_hi_q   <= '0;
      act_lo_q   <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_vld_q <= 1'b0;
      sig_q      <= 1'b0;
      pd_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_hi_q   <= act_hi_d;
      act_lo_q   <= act_lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
      sig_q      <= sig_d;
      pd_q       <= pd_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready   = !pend_vld_q;
  assign sig_out     = sig_q;
  assign period_done = pd_q;
  assign cfg_err     = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_duty_cycle_gen.sv
// tb/tb_duty_cycle_gen.sv - directed self-checking bench for duty_cycle_gen
module tb_duty_cycle_gen;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic [31:0] cfg_high_cnt;
  logic [31:0] cfg_low_cnt;
  logic        cfg_ready;
  logic        sig_out;
  logic        period_done;
  logic        cfg_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  duty_cycle_gen #(.CNT_W(32)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_high_cnt (cfg_high_cnt),
    .cfg_low_cnt  (cfg_low_cnt),
    .sig_out      (sig_out),
    .period_done  (period_done),
    .cfg_err      (cfg_err),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic offer(input logic [31:0] h, input logic [31:0] l);
    cfg_valid    = 1'b1;
    cfg_high_cnt = h;
    cfg_low_cnt  = l;
    @(negedge sys_clk);
    cfg_valid    = 1'b0;
  endtask

  // Samples n consecutive cycles (bit i = cycle i) and compares whole traces.
  task automatic trace(input string tag, input int n, input logic [63:0] es,
                       input logic [63:0] ep, input logic [63:0] er, input logic [63:0] eb);
    logic [63:0] s, p, r, b;
    s = '0; p = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      s[i] = sig_out;
      p[i] = period_done;
      r[i] = cfg_ready;
      b[i] = busy;
      @(negedge sys_clk);
    end
    check({tag, "_sig"}, s, es);
    check({tag, "_done"}, p, ep);
    check({tag, "_ready"}, r, er);
    check({tag, "_busy"}, b, eb);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wait_cnt, hi_cnt, lo_cnt;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_high_cnt = '0; cfg_low_cnt = '0;
    tick(2);
    check("rst_sig", 64'(sig_out), 64'd0);
    check("rst_done", 64'(period_done), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd1);
    rst_n = 1'b1;
    tick(1);

    en = 1'b1;
    offer(32'd3, 32'd5);
    check("t1_ready_pend", 64'(cfg_ready), 64'd0);
    check("t1_busy_pend", 64'(busy), 64'd0);
    tick(1);
    trace("t1", 16, 64'h0707, 64'h8080, 64'hFFFF, 64'hFFFF);

    cfg_valid = 1'b1; cfg_high_cnt = 32'd10; cfg_low_cnt = 32'd2;
    tick(1);
    cfg_valid = 1'b0;
    trace("t2", 19, 64'h1FF83, 64'h40040, 64'h7FF80, 64'h7FFFF);

    cfg_valid = 1'b1; cfg_high_cnt = 32'd0; cfg_low_cnt = 32'd0;
    tick(1);
    cfg_valid = 1'b0;
    check("t3_err_pulse", 64'(cfg_err), 64'd1);
    check("t3_err_ready", 64'(cfg_ready), 64'd1);
    check("t3_err_sig", 64'(sig_out), 64'd1);
    tick(1);
    check("t3_err_clear", 64'(cfg_err), 64'd0);
    offer(32'd0, 32'd4);
    trace("t3_lo_only", 17, 64'h7F, 64'h11100, 64'h1FE00, 64'h1FFFF);
    offer(32'd4, 32'd0);
    trace("t3_hi_only", 11, 64'h7F8, 64'h444, 64'h7F8, 64'h7FF);

    offer(32'd6, 32'd6);
    tick(4);
    en = 1'b0;
    trace("t4_drain", 11, 64'h1F, 64'h400, 64'h7FF, 64'h7FF);
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_sig", 64'(sig_out), 64'd0);
    en = 1'b1;
    tick(1);
    check("t4_restart_sig", 64'(sig_out), 64'd1);
    check("t4_restart_busy", 64'(busy), 64'd1);

    tick(11);
    check("t5_pre_done", 64'(period_done), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_done", 64'(period_done), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_sig", 64'(sig_out), 64'd0);
    check("t5_async_ready", 64'(cfg_ready), 64'd1);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick(2);
    check("t5_post_busy", 64'(busy), 64'd0);
    check("t5_post_ready", 64'(cfg_ready), 64'd1);

    offer(32'd1000, 32'd3000);
    wait_cnt = 0;
    while (sig_out !== 1'b1 && wait_cnt < 10) begin
      @(negedge sys_clk);
      wait_cnt++;
    end
    check("t6_start_latency", 64'(wait_cnt), 64'd1);
    hi_cnt = 0;
    while (sig_out === 1'b1 && hi_cnt < 5000) begin
      hi_cnt++;
      @(negedge sys_clk);
    end
    lo_cnt = 0;
    while (sig_out === 1'b0 && lo_cnt < 5000) begin
      lo_cnt++;
      @(negedge sys_clk);
    end
    check("t6_loop_high", 64'(hi_cnt), 64'd1000);
    check("t6_loop_low", 64'(lo_cnt), 64'd3000);

    #2 rst_n = 1'b0;
    #1;
    check("t6_async_hi_sig", 64'(sig_out), 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick(2);
    check("t6_post_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
